// File: rtl/vscale_lsu_pkg.sv
// Shared definitions for the vscale load/store unit: funct3 memory-size
// encodings, FSM state encoding and the alignment check.
package vscale_lsu_pkg;

  localparam int XLEN = 32;

  // funct3 memory-access sizes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_t;

  // Illegal sizes (3/6/7) are folded into the misaligned trap so they never reach the bus.
  function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = offset[0];
      F3_W:        mis = (offset != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/vscale_lsu_align.sv
// Purely combinational lane handling: store data replication and byte
// strobes on one side, load extraction and extension on the other.
// Kept free of state so an instruction-side adapter can reuse it.
module vscale_lsu_align
  import vscale_lsu_pkg::*;
(
  input  logic [2:0]      i_st_size,
  input  logic [1:0]      i_st_offset,
  input  logic [XLEN-1:0] i_st_wdata,
  input  logic [2:0]      i_ld_size,
  input  logic [1:0]      i_ld_offset,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_st_wdata,
  output logic [3:0]      o_st_wstrb,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] w_ld_shifted;

  // Store side: replicate the right-justified datum into every lane and pick strobes.
  always_comb begin
    o_st_wdata = i_st_wdata;
    o_st_wstrb = 4'b0000;
    case (i_st_size)
      F3_B, F3_BU: begin
        o_st_wdata = {4{i_st_wdata[7:0]}};
        o_st_wstrb = 4'b0001 << i_st_offset;
      end
      F3_H, F3_HU: begin
        o_st_wdata = {2{i_st_wdata[15:0]}};
        o_st_wstrb = 4'b0011 << i_st_offset;
      end
      F3_W: begin
        o_st_wdata = i_st_wdata;
        o_st_wstrb = 4'b1111;
      end
      default: begin
        o_st_wdata = i_st_wdata;
        o_st_wstrb = 4'b0000;
      end
    endcase
  end

  // Load side: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    w_ld_shifted = i_ld_rdata >> {i_ld_offset, 3'b000};
    case (i_ld_size)
      F3_B:    o_ld_data = {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
      F3_H:    o_ld_data = {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      F3_W:    o_ld_data = i_ld_rdata;
      F3_BU:   o_ld_data = {24'd0, w_ld_shifted[7:0]};
      F3_HU:   o_ld_data = {16'd0, w_ld_shifted[15:0]};
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/vscale_lsu.sv
// Load/store unit: turns the DX-stage data-memory access into a single
// outstanding word-aligned bus request and returns WB-stage results.
//
// state | meaning
// IDLE  | no access in flight; DX access may issue directly to the bus
// REQ   | request registered and held on the bus until accepted
// RESP  | request accepted, waiting for the bus response
// FAULT | one-cycle local trap for a misaligned / illegal-size access
//
// Combinational paths that need timing constraints:
//   i_bus_resp_valid -> o_dmem_wait -> (core) i_dmem_en -> o_bus_req_valid
//   DX inputs (i_dmem_*) -> o_bus_req_*
module vscale_lsu
  import vscale_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_dmem_en,
  input  logic            i_dmem_wen,
  input  logic [2:0]      i_dmem_size,
  input  logic [XLEN-1:0] i_dmem_addr,
  input  logic [XLEN-1:0] i_dmem_wdata,
  output logic            o_dmem_wait,
  output logic            o_dmem_badmem_e,
  output logic [XLEN-1:0] o_load_data_WB,
  output logic            o_bus_req_valid,
  input  logic            i_bus_req_ready,
  output logic [XLEN-1:0] o_bus_req_addr,
  output logic            o_bus_req_wen,
  output logic [3:0]      o_bus_req_wstrb,
  output logic [XLEN-1:0] o_bus_req_wdata,
  input  logic            i_bus_resp_valid,
  input  logic [XLEN-1:0] i_bus_resp_rdata,
  input  logic            i_bus_resp_err
);

  lsu_state_t      r_state;

  // Request held across REQ cycles so the bus sees a stable value.
  logic [XLEN-1:0] r_req_addr;
  logic            r_req_wen;
  logic [3:0]      r_req_wstrb;
  logic [XLEN-1:0] r_req_wdata;

  // Per-access context needed when the response arrives in WB.
  logic [1:0]      r_wb_offset;
  logic [2:0]      r_wb_size;
  logic            r_wb_wen;

  logic            w_misaligned;
  logic            w_accept;
  logic            w_dx_issue;
  logic            w_resp_done;
  logic [XLEN-1:0] w_st_wdata;
  logic [3:0]      w_st_wstrb;
  logic [XLEN-1:0] w_ld_data;

  vscale_lsu_align u_align (
    .i_st_size   (i_dmem_size),
    .i_st_offset (i_dmem_addr[1:0]),
    .i_st_wdata  (i_dmem_wdata),
    .i_ld_size   (r_wb_size),
    .i_ld_offset (r_wb_offset),
    .i_ld_rdata  (i_bus_resp_rdata),
    .o_st_wdata  (w_st_wdata),
    .o_st_wstrb  (w_st_wstrb),
    .o_ld_data   (w_ld_data)
  );

  // A new DX access can be taken whenever nothing is outstanding, including
  // the cycle in which the previous response completes.
  always_comb begin
    w_misaligned = lsu_misaligned(i_dmem_size, i_dmem_addr[1:0]);
    w_resp_done  = (r_state == ST_RESP) && i_bus_resp_valid;
    w_accept     = (r_state == ST_IDLE) || (r_state == ST_FAULT) || w_resp_done;
    w_dx_issue   = w_accept && i_dmem_en && !w_misaligned;
  end

  // Bus request: registered copy while in REQ, otherwise straight from DX.
  always_comb begin
    if (r_state == ST_REQ) begin
      o_bus_req_valid = 1'b1;
      o_bus_req_addr  = r_req_addr;
      o_bus_req_wen   = r_req_wen;
      o_bus_req_wstrb = r_req_wstrb;
      o_bus_req_wdata = r_req_wdata;
    end else begin
      o_bus_req_valid = w_dx_issue;
      o_bus_req_addr  = {i_dmem_addr[XLEN-1:2], 2'b00};
      o_bus_req_wen   = i_dmem_wen;
      o_bus_req_wstrb = (w_dx_issue && i_dmem_wen) ? w_st_wstrb : 4'b0000;
      o_bus_req_wdata = w_st_wdata;
    end
  end

  // WB-stage status and load result.
  always_comb begin
    o_dmem_wait     = (r_state == ST_REQ) || ((r_state == ST_RESP) && !i_bus_resp_valid);
    o_dmem_badmem_e = (r_state == ST_FAULT) || (w_resp_done && i_bus_resp_err);
    o_load_data_WB  = (w_resp_done && !i_bus_resp_err && !r_wb_wen) ? w_ld_data : '0;
  end

  // Sequencing FSM; also captures WB context and the held request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_req_addr  <= '0;
      r_req_wen   <= 1'b0;
      r_req_wstrb <= 4'b0000;
      r_req_wdata <= '0;
      r_wb_offset <= 2'b00;
      r_wb_size   <= 3'd0;
      r_wb_wen    <= 1'b0;
    end else if (r_state == ST_REQ) begin
      if (i_bus_req_ready) begin
        r_state <= ST_RESP;
      end
    end else if (w_accept) begin
      if (i_dmem_en) begin
        r_wb_offset <= i_dmem_addr[1:0];
        r_wb_size   <= i_dmem_size;
        r_wb_wen    <= i_dmem_wen;
        if (w_misaligned) begin
          r_state <= ST_FAULT;
        end else if (i_bus_req_ready) begin
          r_state <= ST_RESP;
        end else begin
          r_state     <= ST_REQ;
          r_req_addr  <= {i_dmem_addr[XLEN-1:2], 2'b00};
          r_req_wen   <= i_dmem_wen;
          r_req_wstrb <= i_dmem_wen ? w_st_wstrb : 4'b0000;
          r_req_wdata <= w_st_wdata;
        end
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_vscale_lsu.sv
// Self-checking bench for vscale_lsu: a table of single-cycle accesses
// streamed back to back on a zero-wait bus with a WB scoreboard, then
// hand-written stall, back-to-back and reset-in-flight sequences.
module tb_vscale_lsu;
  import vscale_lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_dmem_en;
  logic        i_dmem_wen;
  logic [2:0]  i_dmem_size;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic        o_dmem_wait;
  logic        o_dmem_badmem_e;
  logic [31:0] o_load_data_WB;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready;
  logic [31:0] o_bus_req_addr;
  logic        o_bus_req_wen;
  logic [3:0]  o_bus_req_wstrb;
  logic [31:0] o_bus_req_wdata;
  logic        i_bus_resp_valid;
  logic [31:0] i_bus_resp_rdata;
  logic        i_bus_resp_err;

  int errors = 0;
  int checks = 0;

  vscale_lsu dut (
    .clk              (clk),
    .reset            (reset),
    .i_dmem_en        (i_dmem_en),
    .i_dmem_wen       (i_dmem_wen),
    .i_dmem_size      (i_dmem_size),
    .i_dmem_addr      (i_dmem_addr),
    .i_dmem_wdata     (i_dmem_wdata),
    .o_dmem_wait      (o_dmem_wait),
    .o_dmem_badmem_e  (o_dmem_badmem_e),
    .o_load_data_WB   (o_load_data_WB),
    .o_bus_req_valid  (o_bus_req_valid),
    .i_bus_req_ready  (i_bus_req_ready),
    .o_bus_req_addr   (o_bus_req_addr),
    .o_bus_req_wen    (o_bus_req_wen),
    .o_bus_req_wstrb  (o_bus_req_wstrb),
    .o_bus_req_wdata  (o_bus_req_wdata),
    .i_bus_resp_valid (i_bus_resp_valid),
    .i_bus_resp_rdata (i_bus_resp_rdata),
    .i_bus_resp_err   (i_bus_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_bad;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    string       name;
    logic        bad;
    logic [31:0] load;
  } wb_exp_t;

  localparam int NV = 12;
  vec_t    vecs[NV];
  wb_exp_t sb[$];

  function automatic vec_t mk(input string name, input logic wen, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic exp_req,
                              input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wdata, input logic exp_bad,
                              input logic [31:0] exp_load);
    vec_t v;
    v.name = name; v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
    v.exp_wdata = exp_wdata; v.exp_bad = exp_bad; v.exp_load = exp_load;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dx(input logic en, input logic wen, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    i_dmem_en = en; i_dmem_wen = wen; i_dmem_size = size;
    i_dmem_addr = addr; i_dmem_wdata = wdata;
  endtask

  task automatic drive_resp(input logic v, input logic err, input logic [31:0] rdata);
    i_bus_resp_valid = v; i_bus_resp_err = err; i_bus_resp_rdata = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pend;
    logic [31:0] pend_rdata;
    wb_exp_t     e;

    vecs[0]  = mk("lw_100",   0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1, 32'h100, 4'b0000, 32'h0,        0, 32'hDEADBEEF);
    vecs[1]  = mk("lb_103",   0, F3_B,  32'h103, 32'h0,        32'h80000000, 1, 32'h100, 4'b0000, 32'h0,        0, 32'hFFFFFF80);
    vecs[2]  = mk("lbu_103",  0, F3_BU, 32'h103, 32'h0,        32'h80000000, 1, 32'h100, 4'b0000, 32'h0,        0, 32'h00000080);
    vecs[3]  = mk("lhu_102",  0, F3_HU, 32'h102, 32'h0,        32'hBEEF0000, 1, 32'h100, 4'b0000, 32'h0,        0, 32'h0000BEEF);
    vecs[4]  = mk("sb_201",   1, F3_B,  32'h201, 32'h12345678, 32'hFFFFFFFF, 1, 32'h200, 4'b0010, 32'h78787878, 0, 32'h0);
    vecs[5]  = mk("sh_202",   1, F3_H,  32'h202, 32'h12345678, 32'hFFFFFFFF, 1, 32'h200, 4'b1100, 32'h56785678, 0, 32'h0);
    vecs[6]  = mk("lw_mis",   0, F3_W,  32'h102, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        1, 32'h0);
    vecs[7]  = mk("size3",    0, 3'd3,  32'h100, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        1, 32'h0);
    vecs[8]  = mk("lh_106",   0, F3_H,  32'h106, 32'h0,        32'h80010000, 1, 32'h104, 4'b0000, 32'h0,        0, 32'hFFFF8001);
    vecs[9]  = mk("sw_30c",   1, F3_W,  32'h30C, 32'hCAFEBABE, 32'h5A5A5A5A, 1, 32'h30C, 4'b1111, 32'hCAFEBABE, 0, 32'h0);
    vecs[10] = mk("lhu_mis",  0, F3_HU, 32'h101, 32'h0,        32'h0,        0, 32'h0,   4'b0000, 32'h0,        1, 32'h0);
    vecs[11] = mk("lb_100",   0, F3_B,  32'h100, 32'h0,        32'h0000007F, 1, 32'h100, 4'b0000, 32'h0,        0, 32'h0000007F);

    reset = 1'b1;
    drive_dx(0, 0, 3'd0, 32'h0, 32'h0);
    drive_resp(0, 0, 32'h0);
    i_bus_req_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #2;
    chk("rst_req_valid", o_bus_req_valid, 0);
    chk("rst_wait", o_dmem_wait, 0);
    chk("rst_badmem", o_dmem_badmem_e, 0);
    chk("rst_load", o_load_data_WB, 0);
    chk("rst_wstrb", o_bus_req_wstrb, 0);

    // Table: one access per cycle on a zero-wait bus; response for access i
    // is returned in the cycle that issues access i+1.
    pend = 1'b0;
    pend_rdata = '0;
    for (int i = 0; i <= NV; i++) begin
      cyc();
      drive_resp(pend, 0, pend_rdata);
      i_bus_req_ready = 1'b1;
      if (i < NV) drive_dx(1, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      else        drive_dx(0, 0, 3'd0, 32'h0, 32'h0);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, "_wait"}, o_dmem_wait, 0);
        chk({e.name, "_badmem"}, o_dmem_badmem_e, e.bad);
        chk({e.name, "_load"}, o_load_data_WB, e.load);
      end
      if (i < NV) begin
        chk({vecs[i].name, "_req_valid"}, o_bus_req_valid, vecs[i].exp_req);
        if (vecs[i].exp_req) begin
          chk({vecs[i].name, "_req_addr"}, o_bus_req_addr, vecs[i].exp_addr);
          chk({vecs[i].name, "_req_wen"}, o_bus_req_wen, vecs[i].wen);
          chk({vecs[i].name, "_req_wstrb"}, o_bus_req_wstrb, vecs[i].exp_wstrb);
          if (vecs[i].wen) chk({vecs[i].name, "_req_wdata"}, o_bus_req_wdata, vecs[i].exp_wdata);
        end
        e.name = vecs[i].name; e.bad = vecs[i].exp_bad; e.load = vecs[i].exp_load;
        sb.push_back(e);
        pend = vecs[i].exp_req;
        pend_rdata = vecs[i].rdata;
      end
    end
    chk("sb_drained", sb.size(), 0);

    // Stall: ready low two cycles, then response three cycles after acceptance with an error.
    cyc();
    drive_resp(0, 0, 32'h0);
    i_bus_req_ready = 1'b0;
    drive_dx(1, 0, F3_W, 32'h400, 32'h0);
    #2;
    chk("stall_a_valid", o_bus_req_valid, 1);
    chk("stall_a_addr", o_bus_req_addr, 32'h400);
    chk("stall_a_wait", o_dmem_wait, 0);
    cyc();
    drive_dx(1, 1, F3_BU, 32'h7F9, 32'hFFFFFFFF);
    #2;
    chk("stall_b_valid", o_bus_req_valid, 1);
    chk("stall_b_addr", o_bus_req_addr, 32'h400);
    chk("stall_b_wen", o_bus_req_wen, 0);
    chk("stall_b_wstrb", o_bus_req_wstrb, 0);
    chk("stall_b_wait", o_dmem_wait, 1);
    cyc();
    i_bus_req_ready = 1'b1;
    #2;
    chk("stall_c_valid", o_bus_req_valid, 1);
    chk("stall_c_addr", o_bus_req_addr, 32'h400);
    chk("stall_c_wait", o_dmem_wait, 1);
    drive_dx(1, 0, F3_W, 32'h500, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #2;
      chk("stall_resp_valid", o_bus_req_valid, 0);
      chk("stall_resp_wait", o_dmem_wait, 1);
      chk("stall_resp_badmem", o_dmem_badmem_e, 0);
    end
    cyc();
    drive_resp(1, 1, 32'h12345678);
    #2;
    chk("stall_err_wait", o_dmem_wait, 0);
    chk("stall_err_badmem", o_dmem_badmem_e, 1);
    chk("stall_err_load", o_load_data_WB, 0);
    chk("b2b_valid", o_bus_req_valid, 1);
    chk("b2b_addr", o_bus_req_addr, 32'h500);
    cyc();
    drive_resp(1, 0, 32'h11223344);
    drive_dx(0, 0, 3'd0, 32'h0, 32'h0);
    #2;
    chk("b2b_load", o_load_data_WB, 32'h11223344);
    chk("b2b_badmem", o_dmem_badmem_e, 0);
    chk("b2b_wait", o_dmem_wait, 0);

    // Reset while waiting in RESP; the late response must be ignored.
    cyc();
    drive_resp(0, 0, 32'h0);
    drive_dx(1, 0, F3_W, 32'h600, 32'h0);
    #2;
    chk("rst_mid_issue", o_bus_req_valid, 1);
    cyc();
    drive_dx(0, 0, 3'd0, 32'h0, 32'h0);
    reset = 1'b1;
    #2;
    chk("rst_mid_wait", o_dmem_wait, 1);
    cyc();
    reset = 1'b0;
    drive_resp(1, 1, 32'hAAAA5555);
    #2;
    chk("stray_badmem", o_dmem_badmem_e, 0);
    chk("stray_load", o_load_data_WB, 0);
    chk("stray_wait", o_dmem_wait, 0);
    chk("stray_valid", o_bus_req_valid, 0);
    cyc();
    drive_resp(0, 0, 32'h0);
    i_bus_req_ready = 1'b0;
    drive_dx(1, 0, F3_HU, 32'h702, 32'h0);
    #2;
    chk("post_rst_valid", o_bus_req_valid, 1);
    chk("post_rst_addr", o_bus_req_addr, 32'h700);
    chk("post_rst_wait", o_dmem_wait, 0);
    cyc();
    drive_dx(0, 0, 3'd0, 32'h0, 32'h0);
    i_bus_req_ready = 1'b1;
    #2;
    chk("post_rst_req_wait", o_dmem_wait, 1);
    cyc();
    drive_resp(1, 0, 32'h0BADF00D);
    #2;
    chk("post_rst_load", o_load_data_WB, 32'h00000BAD);
    chk("post_rst_done_wait", o_dmem_wait, 0);
    cyc();
    drive_resp(0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
